// File: rtl/apb_pkg.sv
// Shared APB master definitions: FSM state encoding and width helpers.
package apb_pkg;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb_state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  // Slave-index field width; never narrower than one bit.
  function automatic int unsigned sel_bits(input int unsigned n);
    return (clog2(n) > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_rdata_mux.sv
// N:1 mux of per-slave prdata/pready, selected by the captured slave index.
module apb_rdata_mux
  import apb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned SLAVES     = 2
) (
  input  logic [SLAVES*DATA_WIDTH-1:0] prdata_i,
  input  logic [SLAVES-1:0]            pready_i,
  input  logic [sel_bits(SLAVES)-1:0]  sel_i,
  output logic [DATA_WIDTH-1:0]        rdata_c_o,
  output logic                         ready_c_o
);

  localparam int unsigned SEL_BITS = sel_bits(SLAVES);

  always_comb begin : mux
    rdata_c_o = '0;
    ready_c_o = 1'b0;
    for (int unsigned i = 0; i < SLAVES; i++) begin
      if (sel_i == SEL_BITS'(i)) begin
        rdata_c_o = prdata_i[i*DATA_WIDTH +: DATA_WIDTH];
        ready_c_o = pready_i[i];
      end
    end
  end

endmodule

// File: rtl/apb_master_nx.sv
// APB master bridge for SLAVES slaves with wait states, back-to-back and decode errors.
// Define APB_TIMEOUT_EN to abort ACCESS phases that wait TIMEOUT_CYCLES without pready.
module apb_master_nx
  import apb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter int unsigned SLAVES         = 2,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                                  clock_i,
  input  logic                                  reset_i,
  input  logic                                  transfer_i,
  input  logic                                  rw_i,
  input  logic [sel_bits(SLAVES)+ADDR_WIDTH-1:0] address_i,
  input  logic [DATA_WIDTH-1:0]                 write_data_i,
  output logic                                  busy_o,
  output logic                                  done_o,
  output logic                                  error_o,
  output logic [DATA_WIDTH-1:0]                 read_data_out_o,
  output logic [SLAVES-1:0]                     psel_o,
  output logic                                  penable_o,
  output logic                                  pwrite_o,
  output logic [ADDR_WIDTH-1:0]                 paddr_o,
  output logic [DATA_WIDTH-1:0]                 pwdata_o,
  input  logic [SLAVES*DATA_WIDTH-1:0]          prdata_i,
  input  logic [SLAVES-1:0]                     pready_i
);

  localparam int unsigned SEL_BITS = sel_bits(SLAVES);

  apb_state_e state_q, state_d;

  logic [SEL_BITS-1:0]   sel_q, sel_d;
  logic [SLAVES-1:0]     psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  busy_q, busy_d;
  logic                  miss_pend_q, miss_pend_d;
  logic                  load_c;

  logic [SEL_BITS-1:0]   cap_idx_c;
  logic                  cap_miss_c;
  logic [DATA_WIDTH-1:0] mux_rdata_c;
  logic                  ready_c;
  logic                  timeout_c;

  assign cap_idx_c  = address_i[ADDR_WIDTH +: SEL_BITS];
  assign cap_miss_c = (32'(cap_idx_c) >= SLAVES);

  apb_rdata_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .SLAVES     (SLAVES)
  ) u_rdata_mux (
    .prdata_i  (prdata_i),
    .pready_i  (pready_i),
    .sel_i     (sel_q),
    .rdata_c_o (mux_rdata_c),
    .ready_c_o (ready_c)
  );

`ifdef APB_TIMEOUT_EN
  localparam int unsigned TW = sel_bits(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tcnt_q, tcnt_d;

  // Counts ACCESS cycles without pready; cleared on every SETUP.
  always_comb begin : tcnt_comb
    tcnt_d = tcnt_q;
    if (state_q == APB_SETUP) begin
      tcnt_d = '0;
    end else if ((state_q == APB_ACCESS) && !ready_c) begin
      tcnt_d = tcnt_q + TW'(1);
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin : tcnt_reg
    if (reset_i) tcnt_q <= '0;
    else         tcnt_q <= tcnt_d;
  end

  assign timeout_c = (state_q == APB_ACCESS) && (tcnt_q == TW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_c;
  assign unused_timeout_c = |32'(TIMEOUT_CYCLES);
  assign timeout_c        = 1'b0;
`endif

  always_ff @(posedge clock_i or posedge reset_i) begin : state_reg
    if (reset_i) begin
      state_q     <= APB_IDLE;
      sel_q       <= '0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rdata_q     <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      busy_q      <= 1'b0;
      miss_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rdata_q     <= rdata_d;
      done_q      <= done_d;
      error_q     <= error_d;
      busy_q      <= busy_d;
      miss_pend_q <= miss_pend_d;
    end
  end

  // A decode miss never enters SETUP; it only produces a done/error pulse.
  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      APB_IDLE: begin
        if (!miss_pend_q && transfer_i && !cap_miss_c) state_d = APB_SETUP;
      end
      APB_SETUP: state_d = APB_ACCESS;
      APB_ACCESS: begin
        if (ready_c) begin
          state_d = (transfer_i && !cap_miss_c) ? APB_SETUP : APB_IDLE;
        end else if (timeout_c) begin
          state_d = APB_IDLE;
        end
      end
      default: state_d = APB_IDLE;
    endcase
  end

  always_comb begin : out_comb
    sel_d       = sel_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rdata_d     = rdata_q;
    done_d      = 1'b0;
    error_d     = 1'b0;
    miss_pend_d = 1'b0;
    load_c      = 1'b0;
    busy_d      = (state_d != APB_IDLE);
    case (state_q)
      APB_IDLE: begin
        if (miss_pend_q) begin
          done_d  = 1'b1;
          error_d = 1'b1;
        end else if (transfer_i) begin
          if (cap_miss_c) begin
            done_d  = 1'b1;
            error_d = 1'b1;
          end else begin
            load_c = 1'b1;
          end
        end
      end
      APB_SETUP: penable_d = 1'b1;
      APB_ACCESS: begin
        if (ready_c) begin
          done_d    = 1'b1;
          psel_d    = '0;
          penable_d = 1'b0;
          if (!pwrite_q) rdata_d = mux_rdata_c;
          // Back-to-back miss: report it one cycle after this completion.
          if (transfer_i) begin
            if (cap_miss_c) miss_pend_d = 1'b1;
            else            load_c      = 1'b1;
          end
        end else if (timeout_c) begin
          done_d    = 1'b1;
          error_d   = 1'b1;
          psel_d    = '0;
          penable_d = 1'b0;
        end
      end
      default: begin
        psel_d    = '0;
        penable_d = 1'b0;
      end
    endcase
    if (load_c) begin
      sel_d     = cap_idx_c;
      psel_d    = SLAVES'(1) << cap_idx_c;
      penable_d = 1'b0;
      pwrite_d  = rw_i;
      paddr_d   = address_i[ADDR_WIDTH-1:0];
      pwdata_d  = write_data_i;
    end
  end

  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign error_o         = error_q;
  assign read_data_out_o = rdata_q;
  assign psel_o          = psel_q;
  assign penable_o       = penable_q;
  assign pwrite_o        = pwrite_q;
  assign paddr_o         = paddr_q;
  assign pwdata_o        = pwdata_q;

endmodule

// File: tb/tb_apb_master_nx.sv
// Self-checking bench for apb_master_nx (3 slaves, 8-bit data, 5-bit local address).
module tb_apb_master_nx;

  logic        clk = 1'b0;
  logic        rst;
  logic        transfer;
  logic        rw;
  logic [6:0]  address;
  logic [7:0]  write_data;
  logic        busy, done, error;
  logic [7:0]  rdo;
  logic [2:0]  psel;
  logic        penable, pwrite;
  logic [4:0]  paddr;
  logic [7:0]  pwdata;
  logic [23:0] prdata;
  logic [2:0]  pready;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  apb_master_nx #(
    .DATA_WIDTH(8), .ADDR_WIDTH(5), .SLAVES(3), .TIMEOUT_CYCLES(16)
  ) dut (
    .clock_i(clk), .reset_i(rst), .transfer_i(transfer), .rw_i(rw),
    .address_i(address), .write_data_i(write_data),
    .busy_o(busy), .done_o(done), .error_o(error), .read_data_out_o(rdo),
    .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite), .paddr_o(paddr),
    .pwdata_o(pwdata), .prdata_i(prdata), .pready_i(pready)
  );

  // Slave environment: target slave answers from its memory, others drive noise.
  logic [7:0]  smem [3][32];
  logic [7:0]  ref_mem [3][32];
  int          tgt = 0;
  logic        rdy_sel = 1'b0;
  logic [23:0] noise_d = '0;
  logic [2:0]  noise_r = '0;
  logic        mem_clr = 1'b1;

  always_comb begin
    for (int s = 0; s < 3; s++) begin
      prdata[s*8 +: 8] = (s == tgt) ? smem[s][paddr] : noise_d[s*8 +: 8];
      pready[s]        = (s == tgt) ? rdy_sel : noise_r[s];
    end
  end

  always @(posedge clk) begin
    for (int s = 0; s < 3; s++) begin
      for (int a = 0; a < 32; a++) begin
        if (mem_clr) smem[s][a] <= 8'h00;
      end
      if (!mem_clr && !rst && psel[s] && penable && pwrite && pready[s])
        smem[s][paddr] <= pwdata;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic stir();
    noise_d = 24'($urandom);
    noise_r = 3'($urandom);
  endtask

  // One isolated request from IDLE; timing and bus values follow the protocol rules.
  task automatic xfer(input logic rw_v, input int idx, input logic [4:0] a, input logic [7:0] d,
                      input int waits, input logic exp_err, input logic [7:0] exp_rd);
    logic [2:0] oh;
    oh = (idx < 3) ? (3'b001 << idx) : 3'b000;
    tgt = idx; rdy_sel = 1'b0; stir();
    transfer = 1'b1; rw = rw_v; address = {2'(idx), a}; write_data = d;
    @(negedge clk);
    transfer = 1'b0; rw = ~rw_v; write_data = ~d; address = 7'($urandom); stir();
    if (idx >= 3) begin
      chk("miss_done", done, 1); chk("miss_err", error, 32'(exp_err));
      chk("miss_psel", psel, 0); chk("miss_busy", busy, 0); chk("miss_rdata", rdo, exp_rd);
    end else begin
      chk("setup_psel", psel, oh); chk("setup_pen", penable, 0); chk("setup_busy", busy, 1);
      chk("setup_done", done, 0); chk("setup_paddr", paddr, a); chk("setup_pwrite", pwrite, rw_v);
      if (rw_v) chk("setup_pwdata", pwdata, d);
      for (int k = 0; k <= waits; k++) begin
        @(negedge clk);
        stir();
        chk("acc_pen", penable, 1); chk("acc_psel", psel, oh); chk("acc_paddr", paddr, a);
        chk("acc_pwrite", pwrite, rw_v); chk("acc_done", done, 0);
        if (rw_v) chk("acc_pwdata", pwdata, d);
        rdy_sel = (k == waits);
      end
      @(negedge clk);
      rdy_sel = 1'b0;
      chk("cpl_done", done, 1); chk("cpl_err", error, 32'(exp_err)); chk("cpl_busy", busy, 0);
      chk("cpl_psel", psel, 0); chk("cpl_pen", penable, 0); chk("cpl_rdata", rdo, exp_rd);
    end
    @(negedge clk);
    chk("pulse_done", done, 0);
  endtask

  typedef struct {
    logic       rw;
    int         idx;
    logic [4:0] a;
    logic [7:0] d;
    int         waits;
    logic       err;
    logic [7:0] rd;
  } vec_t;

  vec_t       tbl [10];
  logic [7:0] model_rd;
  logic       seen;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    for (int s = 0; s < 3; s++)
      for (int a = 0; a < 32; a++) ref_mem[s][a] = 8'h00;
    tbl[0] = '{1'b1, 0, 5'h00, 8'h2a, 0,  1'b0, 8'h00};
    tbl[1] = '{1'b0, 0, 5'h00, 8'h00, 0,  1'b0, 8'h2a};
    tbl[2] = '{1'b1, 1, 5'h1f, 8'h5c, 0,  1'b0, 8'h2a};
    tbl[3] = '{1'b0, 1, 5'h1f, 8'h00, 3,  1'b0, 8'h5c};
    tbl[4] = '{1'b0, 3, 5'h07, 8'h00, 0,  1'b1, 8'h5c};
    tbl[5] = '{1'b1, 2, 5'h10, 8'hc3, 1,  1'b0, 8'h5c};
    tbl[6] = '{1'b0, 2, 5'h10, 8'h00, 2,  1'b0, 8'hc3};
    tbl[7] = '{1'b0, 0, 5'h1f, 8'h00, 0,  1'b0, 8'h00};
    tbl[8] = '{1'b0, 1, 5'h1f, 8'h00, 15, 1'b0, 8'h5c};
    tbl[9] = '{1'b1, 3, 5'h01, 8'h99, 0,  1'b1, 8'h5c};

    rst = 1'b1; transfer = 1'b0; rw = 1'b0; address = '0; write_data = '0;
    #12;
    chk("rst_psel", psel, 0); chk("rst_pen", penable, 0); chk("rst_busy", busy, 0);
    chk("rst_done", done, 0); chk("rst_err", error, 0); chk("rst_rdata", rdo, 0);
    chk("rst_paddr", paddr, 0); chk("rst_pwdata", pwdata, 0); chk("rst_pwrite", pwrite, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0; mem_clr = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      xfer(tbl[i].rw, tbl[i].idx, tbl[i].a, tbl[i].d, tbl[i].waits, tbl[i].err, tbl[i].rd);
      if (tbl[i].rw && tbl[i].idx < 3) ref_mem[tbl[i].idx][tbl[i].a] = tbl[i].d;
      model_rd = tbl[i].rd;
    end

    for (int i = 0; i < 40; i++) begin
      logic       rv;
      int         ix, w;
      logic [4:0] a;
      logic [7:0] d;
      rv = 1'($urandom_range(0, 1)); ix = int'($urandom_range(0, 3));
      a = 5'($urandom); d = 8'($urandom); w = int'($urandom_range(0, 4));
      if (ix < 3 && !rv) model_rd = ref_mem[ix][a];
      xfer(rv, ix, a, d, w, ix == 3, model_rd);
      if (ix < 3 && rv) ref_mem[ix][a] = d;
    end

    // Back-to-back: write then read slave 2, transfer held through completion.
    tgt = 2; rdy_sel = 1'b0;
    transfer = 1'b1; rw = 1'b1; address = {2'd2, 5'h10}; write_data = 8'h77;
    @(negedge clk);
    chk("b2b_setup_psel", psel, 3'b100); chk("b2b_setup_pwdata", pwdata, 8'h77);
    rw = 1'b0; write_data = 8'hff;
    @(negedge clk);
    chk("b2b_acc_pen", penable, 1); chk("b2b_acc_pwrite", pwrite, 1); chk("b2b_acc_pwdata", pwdata, 8'h77);
    rdy_sel = 1'b1;
    @(negedge clk);
    rdy_sel = 1'b0; transfer = 1'b0;
    chk("b2b_done1", done, 1); chk("b2b_err1", error, 0); chk("b2b_setup2_psel", psel, 3'b100);
    chk("b2b_setup2_pen", penable, 0); chk("b2b_setup2_busy", busy, 1); chk("b2b_setup2_pwrite", pwrite, 0);
    @(negedge clk);
    chk("b2b_acc2_pen", penable, 1); chk("b2b_acc2_paddr", paddr, 5'h10); chk("b2b_acc2_done", done, 0);
    rdy_sel = 1'b1;
    @(negedge clk);
    rdy_sel = 1'b0;
    chk("b2b_done2", done, 1); chk("b2b_rdata", rdo, 8'h77); chk("b2b_busy", busy, 0);
    ref_mem[2][5'h10] = 8'h77; model_rd = 8'h77;
    @(negedge clk);

    // Slave 1 never answers.
    tgt = 1; rdy_sel = 1'b0;
    transfer = 1'b1; rw = 1'b0; address = {2'd1, 5'h03};
    @(negedge clk);
    transfer = 1'b0;
    chk("stuck_setup_psel", psel, 3'b010);
`ifdef APB_TIMEOUT_EN
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("to_wait_pen", penable, 1); chk("to_wait_done", done, 0);
    end
    @(negedge clk);
    chk("to_done", done, 1); chk("to_err", error, 1); chk("to_psel", psel, 0);
    chk("to_pen", penable, 0); chk("to_busy", busy, 0); chk("to_rdata", rdo, model_rd);
    @(negedge clk);
    transfer = 1'b1; address = {2'd1, 5'h04};
    @(negedge clk);
    transfer = 1'b0;
    repeat (3) @(negedge clk);
`else
    seen = 1'b0;
    repeat (100) begin
      @(negedge clk);
      seen = seen | done;
    end
    chk("stuck_done_seen", seen, 0); chk("stuck_pen", penable, 1);
    chk("stuck_busy", busy, 1); chk("stuck_psel", psel, 3'b010);
`endif

    // Reset in the middle of ACCESS acts without a clock edge.
    chk("pre_rst_pen", penable, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_psel", psel, 0); chk("arst_pen", penable, 0);
    chk("arst_busy", busy, 0); chk("arst_rdata", rdo, 0);
    @(negedge clk);
    rst = 1'b0; model_rd = 8'h00;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen = seen | done;
    end
    chk("post_rst_no_done", seen, 0);
    xfer(1'b0, 1, 5'h1f, 8'h00, 1, 1'b0, ref_mem[1][5'h1f]);
    xfer(1'b1, 0, 5'h0a, 8'h3c, 0, 1'b0, ref_mem[1][5'h1f]);
    xfer(1'b0, 0, 5'h0a, 8'h00, 2, 1'b0, 8'h3c);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
